dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Shares the single data memory (dmem) between two requesters: the processor's load/store port (P)
//   and a debug/DMA loader port (D).
//   - P has priority by default; a wait counter bounds D starvation.
//   - P keeps its combinational single-cycle read path; P is told to stall when it loses arbitration.
//   - Sits between processor/loader and dmem at top level; no other block drives dmem.
// PARAMETERS
//   ADDR_W    32  address width, big-endian bit order [0:ADDR_W-1] as on dmem
//   DATA_W    32  data width, [0:DATA_W-1]
//   MAX_WAIT  4   consecutive lost cycles after which D is force-granted (legal range 1..15)
// PORTS
//   clock       in   1       system clock, rising edge
//   reset       in   1       synchronous, active-low
//   p_req       in   1       P access request (load or store) this cycle
//   p_addr      in   ADDR_W  P address
//   p_wdata     in   DATA_W  P store data
//   p_we        in   1       P write enable
//   p_byte      in   1       P byte access
//   p_half      in   1       P half-word access
//   p_sext      in   1       P sign-extend load
//   p_rdata     out  DATA_W  P load data, combinational from dmem
//   p_stall     out  1       P lost arbitration this cycle; P must hold PC and request
//   d_req       in   1       D access request
//   d_addr, d_wdata, d_we, d_byte, d_half, d_sext   in   as P equivalents
//   d_gnt       out  1       D access performed this cycle
//   d_rdata     out  DATA_W  D load data, registered
//   d_rvalid    out  1       d_rdata valid; 1-cycle pulse the cycle after a D read grant
//   m_addr      out  ADDR_W  to dmem addr
//   m_wdata     out  DATA_W  to dmem data_in
//   m_we, m_byte, m_half, m_sext   out  1   to dmem controls
//   m_rdata     in   DATA_W  from dmem data_out (combinational read)
// BEHAVIOUR
//   - Reset (reset==0 at rising edge): wait_cnt=0, mode=MODE_P, d_rdata=0, d_rvalid=0.
//   - While reset==0: m_we=0, d_gnt=0, p_stall=0 (gated combinationally); no dmem write can occur.
//   - FSM, registered mode:
//       MODE_P : grant P if p_req, else D if d_req.
//       MODE_D : grant D if d_req, else P if p_req.
//   - wait_cnt (4 bits):
//       d_req & ~d_gnt -> wait_cnt+1
//       d_gnt or ~d_req -> wait_cnt=0
//       saturates at MAX_WAIT
//   - Transitions:
//       MODE_P->MODE_D when next wait_cnt == MAX_WAIT.
//       MODE_D->MODE_P after any cycle in MODE_D (granted, or d_req dropped).
//       MODE_D never lasts more than 1 cycle.
//   - Grant is combinational same-cycle; exactly one or zero grants per cycle.
//   - Mem mux: granted requester's addr/wdata/we/byte/half/sext drive m_*.
//     No grant: m_we=0, m_byte=m_half=m_sext=0, m_addr=0, m_wdata=0.
//   - p_stall = p_req & d_gnt.
//   - p_rdata = m_rdata whenever P is granted; 0 otherwise.
//   - D read (d_gnt & ~d_we): d_rdata<=m_rdata, d_rvalid<=1 next edge.
//   - D write: d_rvalid stays 0.
//   - Latency:
//       P: 0 cycles, write at grant edge.
//       D: write at grant edge; read data 1 cycle after grant.
//   - Widths: pure pass-through; no address/data manipulation. Byte/half legality is dmem's concern.
//   - Simultaneous D request and D force: force honoured even if P requests; P stalls exactly 1 cycle.
//   - Reset mid-operation: pending D read's d_rvalid is suppressed; counters cleared; the requester
//     must reissue after reset==1.
// TESTING
//   1. reset=0 for 2 cycles, p_req=d_req=1, p_we=d_we=1 -> m_we=0, d_gnt=0, p_stall=0, d_rvalid=0;
//      dmem unchanged.
//   2. p_req=0, d_req=1 read 0x10 (mem=0xDEADBEEF) -> d_gnt=1 same cycle; next cycle d_rvalid=1,
//      d_rdata=0xDEADBEEF.
//   3. p_req=d_req=1 continuously, MAX_WAIT=4 -> grants P,P,P,P,D(p_stall=1),P,... period 5;
//      P store data never corrupted.
//   4. Both requesting; d_req drops after 2 lost cycles, reasserts -> 4 further lost cycles before
//      d_gnt (counter cleared).
//   5. D byte store addr 0x3, d_wdata=0x000000AB, P idle -> m_we=1, m_byte=1, m_addr=0x3;
//      P read 0x0 next cycle returns byte 3 = 0xAB, other bytes intact.
//   6. Reset asserted the cycle after a D read grant -> d_rvalid stays 0; after release,
//      mode=MODE_P, wait_cnt=0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundle of every signal between the two requesters (P = processor load/store,
// D = debug/DMA loader), the arbiter and the data memory.
// Handshake: a requester holds *_req with its address/controls stable; an access
// happens in a cycle only when that cycle's grant (P: p_req & ~p_stall, D: d_gnt)
// is high. A refused requester keeps the same request up until it is granted.
// The master modport is the environment (requesters + dmem); the slave modport is
// the arbiter.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // processor port
    logic                p_req;
    logic [0:ADDR_W-1]   p_addr;
    logic [0:DATA_W-1]   p_wdata;
    logic                p_we;
    logic                p_byte;
    logic                p_half;
    logic                p_sext;
    logic [0:DATA_W-1]   p_rdata;
    logic                p_stall;
    // debug/DMA loader port
    logic                d_req;
    logic [0:ADDR_W-1]   d_addr;
    logic [0:DATA_W-1]   d_wdata;
    logic                d_we;
    logic                d_byte;
    logic                d_half;
    logic                d_sext;
    logic                d_gnt;
    logic [0:DATA_W-1]   d_rdata;
    logic                d_rvalid;
    // data memory side
    logic [0:ADDR_W-1]   m_addr;
    logic [0:DATA_W-1]   m_wdata;
    logic                m_we;
    logic                m_byte;
    logic                m_half;
    logic                m_sext;
    logic [0:DATA_W-1]   m_rdata;

    modport master (
        output p_req, p_addr, p_wdata, p_we, p_byte, p_half, p_sext,
        input  p_rdata, p_stall,
        output d_req, d_addr, d_wdata, d_we, d_byte, d_half, d_sext,
        input  d_gnt, d_rdata, d_rvalid,
        input  m_addr, m_wdata, m_we, m_byte, m_half, m_sext,
        output m_rdata
    );

    modport slave (
        input  p_req, p_addr, p_wdata, p_we, p_byte, p_half, p_sext,
        output p_rdata, p_stall,
        input  d_req, d_addr, d_wdata, d_we, d_byte, d_half, d_sext,
        output d_gnt, d_rdata, d_rvalid,
        output m_addr, m_wdata, m_we, m_byte, m_half, m_sext,
        input  m_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single data memory. P wins by default; a
// saturating wait counter forces one D grant after MAX_WAIT consecutive lost
// D cycles. Grants are combinational so P keeps its single-cycle load path;
// D read data comes back registered one cycle after its grant.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4     // 1..15
) (
    input  logic        clock,
    input  logic        reset,         // synchronous, active-low
    dmem_arbiter_if.slave bus,
    output logic        dbg_mode,      // 0 = MODE_P, 1 = MODE_D
    output logic [3:0]  dbg_wait_cnt
);

    typedef enum logic {
        MODE_P = 1'b0,
        MODE_D = 1'b1
    } mode_e;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    mode_e             mode_q, mode_d;
    logic [3:0]        wait_q, wait_d;
    logic              p_gnt, d_gnt;
    logic [0:DATA_W-1] d_rdata_q;
    logic              d_rvalid_q;

    // Same-cycle grant; while reset is low nobody is granted, so no write reaches dmem.
    always_comb begin
        p_gnt = 1'b0;
        d_gnt = 1'b0;
        if (reset) begin
            case (mode_q)
                MODE_P: begin
                    p_gnt = bus.p_req;
                    d_gnt = bus.d_req & ~bus.p_req;
                end
                MODE_D: begin
                    d_gnt = bus.d_req;
                    p_gnt = bus.p_req & ~bus.d_req;
                end
                default: begin
                    p_gnt = 1'b0;
                    d_gnt = 1'b0;
                end
            endcase
        end
    end

    // Starvation counter and mode: MODE_D is entered when D has lost MAX_WAIT
    // cycles in a row and always lasts exactly one cycle.
    always_comb begin
        wait_d = 4'd0;
        mode_d = MODE_P;
        if (bus.d_req && !d_gnt) begin
            wait_d = (wait_q >= MAX_WAIT_C) ? MAX_WAIT_C : wait_q + 4'd1;
        end
        if (mode_q == MODE_P && wait_d == MAX_WAIT_C) begin
            mode_d = MODE_D;
        end
    end

    // Memory mux: the granted requester drives dmem; idle bus is all zero.
    always_comb begin
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        bus.m_we    = 1'b0;
        bus.m_byte  = 1'b0;
        bus.m_half  = 1'b0;
        bus.m_sext  = 1'b0;
        if (p_gnt) begin
            bus.m_addr  = bus.p_addr;
            bus.m_wdata = bus.p_wdata;
            bus.m_we    = bus.p_we;
            bus.m_byte  = bus.p_byte;
            bus.m_half  = bus.p_half;
            bus.m_sext  = bus.p_sext;
        end else if (d_gnt) begin
            bus.m_addr  = bus.d_addr;
            bus.m_wdata = bus.d_wdata;
            bus.m_we    = bus.d_we;
            bus.m_byte  = bus.d_byte;
            bus.m_half  = bus.d_half;
            bus.m_sext  = bus.d_sext;
        end
    end

    // State register plus registered D read return.
    always_ff @(posedge clock) begin
        if (!reset) begin
            mode_q     <= MODE_P;
            wait_q     <= 4'd0;
            d_rdata_q  <= '0;
            d_rvalid_q <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            wait_q     <= wait_d;
            d_rvalid_q <= d_gnt & ~bus.d_we;
            if (d_gnt && !bus.d_we) begin
                d_rdata_q <= bus.m_rdata;
            end
        end
    end

    // d_rvalid is also masked by reset so a read granted just before reset
    // never reports data while reset is held.
    assign bus.d_gnt    = d_gnt;
    assign bus.p_stall  = bus.p_req & d_gnt;
    assign bus.p_rdata  = p_gnt ? bus.m_rdata : '0;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.d_rvalid = d_rvalid_q & reset;

    assign dbg_mode     = mode_q;
    assign dbg_wait_cnt = wait_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small big-endian word memory model.
module tb_dmem_arbiter;

    logic       clock;
    logic       reset;
    logic       dbg_mode;
    logic [3:0] dbg_wait_cnt;
    int         checks   = 0;
    int         failures = 0;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifc ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (ifc),
        .dbg_mode     (dbg_mode),
        .dbg_wait_cnt (dbg_wait_cnt)
    );

    // clock/reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // dmem model: 16 words, combinational read, write at rising edge
    logic [0:31] mem [16] = '{32'h11223344, 32'h55667788, 32'h0, 32'h0,
                              32'hDEADBEEF, 32'h0, 32'h0, 32'h0,
                              32'h0, 32'h0, 32'h0, 32'h0,
                              32'h0, 32'h0, 32'h0, 32'h0};

    assign ifc.m_rdata = mem[ifc.m_addr[26:29]];

    always @(posedge clock) begin
        if (ifc.m_we) begin
            if (ifc.m_byte)
                mem[ifc.m_addr[26:29]][ifc.m_addr[30:31]*8 +: 8] <= ifc.m_wdata[24:31];
            else if (ifc.m_half)
                mem[ifc.m_addr[26:29]][ifc.m_addr[30]*16 +: 16] <= ifc.m_wdata[16:31];
            else
                mem[ifc.m_addr[26:29]] <= ifc.m_wdata;
        end
    end

    // checker
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive_p(input logic req, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic we);
        ifc.p_req   = req;
        ifc.p_addr  = addr;
        ifc.p_wdata = wdata;
        ifc.p_we    = we;
        ifc.p_byte  = 1'b0;
        ifc.p_half  = 1'b0;
        ifc.p_sext  = 1'b0;
    endtask

    task automatic drive_d(input logic req, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic we,
                           input logic byte_acc, input logic sext);
        ifc.d_req   = req;
        ifc.d_addr  = addr;
        ifc.d_wdata = wdata;
        ifc.d_we    = we;
        ifc.d_byte  = byte_acc;
        ifc.d_half  = 1'b0;
        ifc.d_sext  = sext;
    endtask

    initial begin
        logic exp_d;
        logic exp_rv;

        // 1: reset held with both ports trying to write
        reset = 1'b0;
        drive_p(1'b1, 32'h0, 32'hFFFF_FFFF, 1'b1);
        drive_d(1'b1, 32'h4, 32'hEEEE_EEEE, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            #1;
            check("rst_m_we",     32'(ifc.m_we),     32'd0);
            check("rst_d_gnt",    32'(ifc.d_gnt),    32'd0);
            check("rst_p_stall",  32'(ifc.p_stall),  32'd0);
            check("rst_d_rvalid", 32'(ifc.d_rvalid), 32'd0);
            tick();
        end
        check("rst_mode",  32'(dbg_mode),     32'd0);
        check("rst_wait",  32'(dbg_wait_cnt), 32'd0);
        check("rst_mem0",  mem[0], 32'h11223344);
        check("rst_mem1",  mem[1], 32'h55667788);

        // release, idle one cycle
        reset = 1'b1;
        drive_p(1'b0, 32'h0, 32'h0, 1'b0);
        drive_d(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();

        // 2: D read of 0x10 with P idle
        drive_d(1'b1, 32'h10, 32'h0, 1'b0, 1'b0, 1'b1);
        #1;
        check("t2_d_gnt",   32'(ifc.d_gnt),   32'd1);
        check("t2_m_addr",  ifc.m_addr,       32'h10);
        check("t2_m_sext",  32'(ifc.m_sext),  32'd1);
        check("t2_p_stall", 32'(ifc.p_stall), 32'd0);
        tick();
        drive_d(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        check("t2_d_rvalid", 32'(ifc.d_rvalid), 32'd1);
        check("t2_d_rdata",  ifc.d_rdata,       32'hDEADBEEF);
        tick();
        #1;
        check("t2_d_rvalid_drop", 32'(ifc.d_rvalid), 32'd0);

        // 3: both requesting; P stores to 0x8, D reads 0x10 -> P,P,P,P,D repeating
        for (int i = 0; i < 10; i++) begin
            drive_p(1'b1, 32'h8, 32'h1000_0000 + 32'(i), 1'b1);
            drive_d(1'b1, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
            #1;
            exp_d  = ((i % 5) == 4);
            exp_rv = (i > 0) && (((i - 1) % 5) == 4);
            check("t3_d_gnt",    32'(ifc.d_gnt),    32'(exp_d));
            check("t3_p_stall",  32'(ifc.p_stall),  32'(exp_d));
            check("t3_m_we",     32'(ifc.m_we),     32'(!exp_d));
            check("t3_d_rvalid", 32'(ifc.d_rvalid), 32'(exp_rv));
            if (exp_d)
                check("t3_p_rdata_stalled", ifc.p_rdata, 32'h0);
            tick();
        end
        drive_p(1'b0, 32'h0, 32'h0, 1'b0);
        drive_d(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        check("t3_d_rvalid_last", 32'(ifc.d_rvalid), 32'd1);
        check("t3_d_rdata_last",  ifc.d_rdata,       32'hDEADBEEF);
        check("t3_p_store",       mem[2],            32'h1000_0008);
        check("t3_mode_back",     32'(dbg_mode),     32'd0);
        tick();

        // 4: D loses 2, drops (counter clears), then needs 4 more losses
        for (int j = 0; j < 8; j++) begin
            drive_p(1'b1, 32'h0, 32'h0, 1'b0);
            drive_d((j != 2), 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
            #1;
            if (j == 2) check("t4_wait_before_drop", 32'(dbg_wait_cnt), 32'd2);
            if (j == 3) check("t4_wait_cleared",     32'(dbg_wait_cnt), 32'd0);
            check("t4_d_gnt",   32'(ifc.d_gnt),   32'(j == 7));
            check("t4_p_stall", 32'(ifc.p_stall), 32'(j == 7));
            if (j != 7) check("t4_p_rdata", ifc.p_rdata, 32'h11223344);
            tick();
        end

        // 5: D byte store 0xAB at 0x3, then P reads word 0x0
        drive_p(1'b0, 32'h0, 32'h0, 1'b0);
        drive_d(1'b1, 32'h3, 32'h0000_00AB, 1'b1, 1'b1, 1'b0);
        #1;
        check("t5_d_gnt",  32'(ifc.d_gnt),  32'd1);
        check("t5_m_we",   32'(ifc.m_we),   32'd1);
        check("t5_m_byte", 32'(ifc.m_byte), 32'd1);
        check("t5_m_half", 32'(ifc.m_half), 32'd0);
        check("t5_m_addr", ifc.m_addr,      32'h3);
        tick();
        drive_p(1'b1, 32'h0, 32'h0, 1'b0);
        drive_d(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        check("t5_p_rdata",  ifc.p_rdata,       32'h112233AB);
        check("t5_d_rvalid", 32'(ifc.d_rvalid), 32'd0);
        check("t5_p_stall",  32'(ifc.p_stall),  32'd0);
        tick();

        // 6: reset the cycle after a D read grant
        drive_p(1'b0, 32'h0, 32'h0, 1'b0);
        drive_d(1'b1, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        check("t6_d_gnt", 32'(ifc.d_gnt), 32'd1);
        tick();
        reset = 1'b0;
        drive_p(1'b1, 32'h0, 32'hFFFF_FFFF, 1'b1);
        drive_d(1'b1, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        check("t6_d_rvalid_in_rst", 32'(ifc.d_rvalid), 32'd0);
        check("t6_m_we_in_rst",     32'(ifc.m_we),     32'd0);
        check("t6_p_stall_in_rst",  32'(ifc.p_stall),  32'd0);
        tick();
        #1;
        check("t6_d_rvalid_after", 32'(ifc.d_rvalid), 32'd0);
        check("t6_mode",           32'(dbg_mode),     32'd0);
        check("t6_wait",           32'(dbg_wait_cnt), 32'd0);
        check("t6_mem0_kept",      mem[0],            32'h112233AB);
        reset = 1'b1;
        for (int j = 0; j < 5; j++) begin
            drive_p(1'b1, 32'h0, 32'h0, 1'b0);
            drive_d(1'b1, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
            #1;
            check("t6_d_gnt_post", 32'(ifc.d_gnt), 32'(j == 4));
            tick();
        end
        drive_p(1'b0, 32'h0, 32'h0, 1'b0);
        drive_d(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        check("t6_d_rvalid_post", 32'(ifc.d_rvalid), 32'd1);

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
